// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: 2-FF synchroniser, polarity normalisation,
// debounced level with press/release pulses, long-press flag and auto-repeat.
module multi_debouncer #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 131071,
   parameter int LONG_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [CHANNELS-1:0] switch_in,
   input  logic [CHANNELS-1:0] repeat_en,
   output logic [CHANNELS-1:0] state,
   output logic [CHANNELS-1:0] trans_up,
   output logic [CHANNELS-1:0] trans_dn,
   output logic [CHANNELS-1:0] long_press,
   output logic [CHANNELS-1:0] long_held,
   output logic [CHANNELS-1:0] repeat_pulse
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {ST_REL, ST_PRS, ST_LONG} hold_t;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic          raw;
         logic          sync0_reg, sync1_reg;
         logic [DW-1:0] dcnt_reg;
         logic          state_reg, up_reg, dn_reg;
         logic          accept, press_acc, rel_acc;
         hold_t         hst_reg, hst_next;
         logic [HW-1:0] hcnt_reg, hcnt_next;
         logic          lp_reg, lp_next, lh_reg, lh_next, rp_reg, rp_next;

         assign raw       = (ACTIVE_LOW != 0) ? ~switch_in[gi] : switch_in[gi];
         assign accept    = (sync1_reg != state_reg) && (dcnt_reg == DEB_LAST);
         assign press_acc = accept & ~state_reg;
         assign rel_acc   = accept & state_reg;

         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
               sync0_reg <= 1'b0;
               sync1_reg <= 1'b0;
               dcnt_reg  <= '0;
               state_reg <= 1'b0;
               up_reg    <= 1'b0;
               dn_reg    <= 1'b0;
            end else begin
               sync0_reg <= raw;
               sync1_reg <= sync0_reg;
               up_reg    <= press_acc;
               dn_reg    <= rel_acc;
               // Any return to the current level restarts the stability count.
               if (sync1_reg == state_reg) begin
                  dcnt_reg <= '0;
               end else if (accept) begin
                  state_reg <= ~state_reg;
                  dcnt_reg  <= '0;
               end else begin
                  dcnt_reg <= dcnt_reg + DW'(1);
               end
            end
         end

         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
               hst_reg  <= ST_REL;
               hcnt_reg <= '0;
               lp_reg   <= 1'b0;
               lh_reg   <= 1'b0;
               rp_reg   <= 1'b0;
            end else begin
               hst_reg  <= hst_next;
               hcnt_reg <= hcnt_next;
               lp_reg   <= lp_next;
               lh_reg   <= lh_next;
               rp_reg   <= rp_next;
            end
         end

         // Release acceptance takes priority over a hold-counter expiry.
         always_comb begin
            hst_next  = hst_reg;
            hcnt_next = hcnt_reg;
            lp_next   = 1'b0;
            lh_next   = lh_reg;
            rp_next   = 1'b0;
            case (hst_reg)
               ST_REL: begin
                  hcnt_next = '0;
                  lh_next   = 1'b0;
                  if (press_acc) hst_next = ST_PRS;
               end
               ST_PRS: begin
                  if (rel_acc) begin
                     hst_next  = ST_REL;
                     hcnt_next = '0;
                  end else if (hcnt_reg == LONG_LAST) begin
                     hst_next  = ST_LONG;
                     hcnt_next = '0;
                     lp_next   = 1'b1;
                     lh_next   = 1'b1;
                  end else begin
                     hcnt_next = hcnt_reg + HW'(1);
                  end
               end
               ST_LONG: begin
                  if (rel_acc) begin
                     hst_next  = ST_REL;
                     hcnt_next = '0;
                     lh_next   = 1'b0;
                  end else if (hcnt_reg == REP_LAST) begin
                     hcnt_next = '0;
                     rp_next   = repeat_en[gi];
                  end else begin
                     hcnt_next = hcnt_reg + HW'(1);
                  end
               end
               default: begin
                  hst_next  = ST_REL;
                  hcnt_next = '0;
                  lh_next   = 1'b0;
               end
            endcase
         end

         assign state[gi]        = state_reg;
         assign trans_up[gi]     = up_reg;
         assign trans_dn[gi]     = dn_reg;
         assign long_press[gi]   = lp_reg;
         assign long_held[gi]    = lh_reg;
         assign repeat_pulse[gi] = rp_reg;
      end
   endgenerate

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: expected pulse vectors are queued per
// cycle by each scenario and compared by a negedge monitor every cycle.
module tb_multi_debouncer;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic [1:0] switch_in = 2'b11;
   logic [1:0] repeat_en = 2'b00;
   logic [1:0] state, trans_up, trans_dn, long_press, long_held, repeat_pulse;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int         c;
      logic [7:0] v;
   } evt_t;
   evt_t sb[$];

   multi_debouncer #(
      .CHANNELS(2), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(20),
      .REPEAT_CYCLES(5), .ACTIVE_LOW(1)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .switch_in(switch_in), .repeat_en(repeat_en),
      .state(state), .trans_up(trans_up), .trans_dn(trans_dn),
      .long_press(long_press), .long_held(long_held), .repeat_pulse(repeat_pulse)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Pulse vector layout: {repeat_pulse, long_press, trans_dn, trans_up}
   always @(negedge CLK) begin : mon
      logic [7:0] obs;
      evt_t       e;
      obs = {repeat_pulse, long_press, trans_dn, trans_up};
      while (sb.size() > 0 && sb[0].c < cyc) begin
         e = sb.pop_front();
         n_tests++; n_fail++;
         $display("FAIL missed_pulse cyc=%0d got=none want=%b", e.c, e.v);
      end
      if (sb.size() > 0 && sb[0].c == cyc) begin
         e = sb.pop_front();
         n_tests++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL pulses cyc=%0d got=%b want=%b", cyc, obs, e.v);
         end else begin
            $display("[TB] cyc=%0d pulses=%b ok", cyc, obs);
         end
      end else if (obs !== 8'h00) begin
         n_tests++; n_fail++;
         $display("FAIL unexpected_pulse cyc=%0d got=%b want=00000000", cyc, obs);
      end
   end

   task automatic expect_evt(input int c, input logic [7:0] v);
      evt_t e;
      int   i;
      for (i = 0; i < sb.size(); i++) begin
         if (sb[i].c == c) begin
            e = sb[i];
            e.v = e.v | v;
            sb[i] = e;
            return;
         end
      end
      e.c = c;
      e.v = v;
      i = 0;
      while (i < sb.size() && sb[i].c < c) i++;
      sb.insert(i, e);
   endtask

   task automatic wait_until(input int c);
      int guard = 0;
      while (cyc < c && guard < 5000) begin
         @(negedge CLK);
         guard++;
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 300) begin
         @(negedge CLK);
         guard++;
      end
      wait_until(cyc + 3);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      n_tests++;
      if ({state, trans_up, trans_dn, long_press, long_held, repeat_pulse} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h want=000",
                  {state, trans_up, trans_dn, long_press, long_held, repeat_pulse});
      end
      RESET_N = 1'b1;
      wait_until(cyc + 12);
      n_tests++;
      if ({state, long_held} !== 4'h0) begin
         n_fail++;
         $display("FAIL idle_after_reset got=%b want=0000", {state, long_held});
      end
   endtask

   task automatic test_clean_press();
      int k;
      k = cyc + 1;
      switch_in[0] = 1'b0;
      expect_evt(k + 9, 8'h01);
      wait_until(k + 8);
      n_tests++;
      if (state !== 2'b00) begin
         n_fail++; $display("FAIL press_early got=%b want=00", state);
      end
      wait_until(k + 9);
      n_tests++;
      if (state !== 2'b01) begin
         n_fail++; $display("FAIL press_state got=%b want=01", state);
      end
      k = cyc + 1;
      switch_in[0] = 1'b1;
      expect_evt(k + 9, 8'h04);
      wait_until(k + 9);
      n_tests++;
      if (state !== 2'b00) begin
         n_fail++; $display("FAIL release_state got=%b want=00", state);
      end
      drain();
   endtask

   task automatic test_bounce();
      int k = 0;
      for (int i = 0; i < 11; i++) begin
         switch_in[0] = ~switch_in[0];
         k = cyc + 1;
         if (i < 10) begin
            wait_until(cyc + 3);
            n_tests++;
            if (state !== 2'b00) begin
               n_fail++; $display("FAIL bounce_state step=%0d got=%b want=00", i, state);
            end
         end
      end
      expect_evt(k + 9, 8'h01);
      wait_until(k + 9);
      n_tests++;
      if (state !== 2'b01) begin
         n_fail++; $display("FAIL bounce_settled got=%b want=01", state);
      end
      k = cyc + 1;
      switch_in[0] = 1'b1;
      expect_evt(k + 9, 8'h04);
      drain();
   endtask

   task automatic test_glitch();
      int k;
      k = cyc + 1;
      switch_in[1] = 1'b0;
      wait_until(k + 6);
      switch_in[1] = 1'b1;
      wait_until(cyc + 15);
      n_tests++;
      if (state !== 2'b00) begin
         n_fail++; $display("FAIL glitch7_state got=%b want=00", state);
      end
      k = cyc + 1;
      switch_in[1] = 1'b0;
      expect_evt(k + 9, 8'h02);
      expect_evt(k + 18, 8'h08);
      wait_until(k + 8);
      switch_in[1] = 1'b1;
      wait_until(k + 9);
      n_tests++;
      if (state !== 2'b10) begin
         n_fail++; $display("FAIL glitch9_state got=%b want=10", state);
      end
      wait_until(k + 18);
      n_tests++;
      if (state !== 2'b00) begin
         n_fail++; $display("FAIL glitch9_release got=%b want=00", state);
      end
      drain();
   endtask

   task automatic test_long_repeat();
      int k, e, l;
      repeat_en = 2'b01;
      k = cyc + 1;
      e = k + 9;
      l = e + 20;
      switch_in[0] = 1'b0;
      expect_evt(e, 8'h01);
      expect_evt(l, 8'h10);
      expect_evt(l + 5, 8'h40);
      expect_evt(l + 10, 8'h40);
      expect_evt(l + 15, 8'h40);
      wait_until(l - 1);
      n_tests++;
      if (long_held !== 2'b00) begin
         n_fail++; $display("FAIL long_held_early got=%b want=00", long_held);
      end
      wait_until(l);
      n_tests++;
      if (long_held !== 2'b01) begin
         n_fail++; $display("FAIL long_held_set got=%b want=01", long_held);
      end
      wait_until(l + 16);
      repeat_en = 2'b00;
      wait_until(l + 27);
      n_tests++;
      if (long_held !== 2'b01) begin
         n_fail++; $display("FAIL long_held_norepeat got=%b want=01", long_held);
      end
      repeat_en = 2'b01;
      expect_evt(l + 30, 8'h40);
      expect_evt(l + 35, 8'h40);
      expect_evt(l + 40, 8'h40);
      expect_evt(l + 45, 8'h04);
      wait_until(l + 35);
      switch_in[0] = 1'b1;
      wait_until(l + 44);
      n_tests++;
      if (long_held !== 2'b01) begin
         n_fail++; $display("FAIL long_held_before_release got=%b want=01", long_held);
      end
      wait_until(l + 45);
      n_tests++;
      if ({state, long_held} !== 4'b0000) begin
         n_fail++; $display("FAIL release_clears_held got=%b want=0000", {state, long_held});
      end
      repeat_en = 2'b00;
      drain();
   endtask

   task automatic test_reset_mid();
      int k, c, r;
      k = cyc + 1;
      switch_in[1] = 1'b0;
      expect_evt(k + 9, 8'h02);
      wait_until(k + 9);
      n_tests++;
      if (state !== 2'b10) begin
         n_fail++; $display("FAIL pre_reset_state got=%b want=10", state);
      end
      c = cyc;
      switch_in[0] = 1'b0;
      wait_until(c + 6);
      #2 RESET_N = 1'b0;
      #1;
      n_tests++;
      if ({state, trans_up, trans_dn, long_press, long_held, repeat_pulse} !== 12'h000) begin
         n_fail++;
         $display("FAIL async_reset got=%h want=000",
                  {state, trans_up, trans_dn, long_press, long_held, repeat_pulse});
      end
      switch_in[1] = 1'b1;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      r = cyc;
      expect_evt(r + 10, 8'h01);
      wait_until(r + 9);
      n_tests++;
      if (state !== 2'b00) begin
         n_fail++; $display("FAIL held_through_reset_early got=%b want=00", state);
      end
      wait_until(r + 10);
      n_tests++;
      if (state !== 2'b01) begin
         n_fail++; $display("FAIL held_through_reset got=%b want=01", state);
      end
      k = cyc + 1;
      switch_in[0] = 1'b1;
      expect_evt(k + 9, 8'h04);
      drain();
   endtask

   task automatic test_back_to_back();
      int c;
      c = cyc;
      switch_in = 2'b00;
      expect_evt(c + 10, 8'h03);
      wait_until(c + 10);
      n_tests++;
      if (state !== 2'b11) begin
         n_fail++; $display("FAIL both_pressed got=%b want=11", state);
      end
      switch_in = 2'b11;
      expect_evt(c + 20, 8'h0C);
      wait_until(c + 20);
      n_tests++;
      if (state !== 2'b00) begin
         n_fail++; $display("FAIL both_released got=%b want=00", state);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_long_repeat();
      test_reset_mid();
      test_back_to_back();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
